// File: rtl/host_req_responder.sv
// Host request responder: queues read/write requests in a FIFO and services
// them one at a time, in order, against a single-port backing memory.
module host_req_responder #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 30,
  parameter int FIFO_DEPTH    = 8,
  parameter int MEM_WORDS     = 1024,
  parameter int READ_LATENCY  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_request_type,
  input  logic [ADDRESS_WIDTH-1:0] in_request_address,
  input  logic [DATA_WIDTH-1:0]    in_request_data,
  output logic                     out_busy,
  output logic                     write_done,
  output logic                     read_done,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     drop_err
);
  localparam int IW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(READ_LATENCY + 1);

  typedef struct packed {
    logic                  wr;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT} state_t;

  entry_t                fifo_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  state_t                state, state_next;
  logic [IW-1:0]         cur_idx;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [LW-1:0]         lat_cnt;
  logic                  push, pop, do_write, do_read;

  // Upper address bits are intentionally dropped so indices alias modulo MEM_WORDS.
  logic unused_addr_hi;
  assign unused_addr_hi = ^in_request_address[ADDRESS_WIDTH-1:IW];

  assign out_busy = (count == CW'(FIFO_DEPTH));
  assign push     = in_valid && !out_busy;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (in_valid && out_busy) drop_err <= 1'b1;
    end
  end

  // NOTE: storage arrays carry no reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (push)
      fifo_q[wr_ptr] <= '{wr: in_request_type, idx: in_request_address[IW-1:0],
                          data: in_request_data};
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[cur_idx] <= cur_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    do_write   = 1'b0;
    do_read    = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = fifo_q[rd_ptr].wr ? WRITE : READ_WAIT;
        end
      end
      WRITE: begin
        do_write   = 1'b1;
        state_next = IDLE;
      end
      READ_WAIT: begin
        if (lat_cnt == '0) begin
          do_read    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_idx    <= '0;
      cur_data   <= '0;
      lat_cnt    <= '0;
      write_done <= 1'b0;
      read_done  <= 1'b0;
      data_out   <= '0;
    end else begin
      write_done <= do_write;
      read_done  <= do_read;
      if (pop) begin
        cur_idx  <= fifo_q[rd_ptr].idx;
        cur_data <= fifo_q[rd_ptr].data;
        lat_cnt  <= LW'(READ_LATENCY - 1);
      end else if (state == READ_WAIT && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (do_read) data_out <= mem[cur_idx];
    end
  end

endmodule

// File: tb/tb_host_req_responder.sv
// Bench for host_req_responder: directed steps with a scoreboard of expected
// completions, popped by a monitor whenever the DUT pulses a done output.
module tb_host_req_responder;
  localparam int DW  = 16;
  localparam int AW  = 30;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_request_type = 1'b0;
  logic [AW-1:0] in_request_address = '0;
  logic [DW-1:0] in_request_data = '0;
  logic          out_busy, write_done, read_done, drop_err;
  logic [DW-1:0] data_out;

  int checks = 0;
  int errors = 0;
  int wd_seen = 0;
  int rd_seen = 0;

  typedef struct {
    bit            wr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model_mem [1024];
  logic [DW-1:0] last_rd = '0;

  host_req_responder #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(8),
    .MEM_WORDS(1024), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_request_type(in_request_type), .in_request_address(in_request_address),
    .in_request_data(in_request_data), .out_busy(out_busy),
    .write_done(write_done), .read_done(read_done),
    .data_out(data_out), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest accepted request.
  always @(negedge clk) begin
    if (rst_n) begin
      check("done_overlap", {31'd0, write_done && read_done}, 32'd0);
      if (write_done) begin
        wd_seen++;
        check("wr_pending", {31'd0, sb.size() > 0 && sb[0].wr}, 32'd1);
        if (sb.size() > 0) sb.delete(0);
      end
      if (read_done) begin
        rd_seen++;
        check("rd_pending", {31'd0, sb.size() > 0 && !sb[0].wr}, 32'd1);
        if (sb.size() > 0) begin
          check("rd_data", {16'd0, data_out}, {16'd0, sb[0].data});
          last_rd = sb[0].data;
          sb.delete(0);
        end
      end else begin
        check("data_hold", {16'd0, data_out}, {16'd0, last_rd});
      end
    end
  end

  // Called at a negedge; drives one request once out_busy is low and returns one cycle later.
  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int g = 0;
    while (out_busy && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("busy_wait", {31'd0, out_busy}, 32'd0);
    if (!out_busy) begin
      in_valid           = 1'b1;
      in_request_type    = wr;
      in_request_address = a;
      in_request_data    = d;
      if (wr) begin
        model_mem[a[9:0]] = d;
        sb.push_back('{wr: 1'b1, data: d});
      end else begin
        sb.push_back('{wr: 1'b0, data: model_mem[a[9:0]]});
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while (sb.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check(tag, sb.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int wd_base;
    int rd_base;

    // Asynchronous reset: outputs clear before any clock edge arrives.
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", {31'd0, out_busy}, 32'd0);
    check("rst_wd", {31'd0, write_done}, 32'd0);
    check("rst_rd", {31'd0, read_done}, 32'd0);
    check("rst_data", {16'd0, data_out}, 32'd0);
    check("rst_drop", {31'd0, drop_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic write then read at addr 5; first request goes in on the first edge after release.
    send(1'b1, 30'd5, 16'h00A5);
    @(negedge clk);
    check("wd_early", {31'd0, write_done}, 32'd0);
    @(negedge clk);
    check("wd_at_a2", {31'd0, write_done}, 32'd1);
    send(1'b0, 30'd5, 16'h0000);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      check("rd_early", {31'd0, read_done}, 32'd0);
    end
    @(negedge clk);
    check("rd_at_a5", {31'd0, read_done}, 32'd1);
    check("rd_a5_data", {16'd0, data_out}, 32'h00A5);
    drain("drain_basic");

    // Aliasing: 0x400 maps onto index 0.
    send(1'b1, 30'h400, 16'h1234);
    send(1'b0, 30'h000, 16'h0000);
    drain("drain_alias");
    check("alias_data", {16'd0, last_rd}, 32'h1234);

    // Writes on consecutive cycles: push+pop coincide at count 7, then the FIFO fills.
    for (int i = 0; i < 14; i++) send(1'b1, AW'(100 + i), DW'(16'hA000 + i));
    check("busy_pushpop_at7", {31'd0, out_busy}, 32'd0);
    send(1'b1, AW'(114), 16'hA00E);
    check("busy_full", {31'd0, out_busy}, 32'd1);
    drain("drain_wrap_wr");
    for (int i = 0; i < 15; i++) send(1'b0, AW'(100 + i), '0);
    drain("drain_wrap_rd");

    // Full streaming pass over the whole memory.
    wd_base = wd_seen;
    rd_base = rd_seen;
    for (int i = 0; i < 1024; i++) send(1'b1, AW'(i), DW'(i));
    for (int i = 0; i < 1024; i++) send(1'b0, AW'(i), '0);
    drain("drain_stream");
    check("stream_wd_count", wd_seen - wd_base, 32'd1024);
    check("stream_rd_count", rd_seen - rd_base, 32'd1024);
    check("stream_drop", {31'd0, drop_err}, 32'd0);

    // Fill the FIFO behind slow reads; a request offered while busy is dropped.
    for (int i = 0; i < 9; i++) send(1'b0, AW'(200 + i), '0);
    check("busy_at_7", {31'd0, out_busy}, 32'd0);
    send(1'b0, AW'(209), '0);
    check("busy_at_8", {31'd0, out_busy}, 32'd1);
    check("drop_before", {31'd0, drop_err}, 32'd0);
    in_valid           = 1'b1;
    in_request_type    = 1'b1;
    in_request_address = 30'd300;
    in_request_data    = 16'hDEAD;
    @(negedge clk);
    in_valid = 1'b0;
    check("drop_set", {31'd0, drop_err}, 32'd1);
    check("busy_after_drop", {31'd0, out_busy}, 32'd1);
    drain("drain_full");
    check("drop_sticky", {31'd0, drop_err}, 32'd1);

    // Reset in the middle of READ_WAIT with three entries queued.
    for (int i = 0; i < 4; i++) send(1'b0, 30'd7, '0);
    #2 rst_n = 1'b0;
    sb.delete();
    last_rd = '0;
    #1;
    check("mid_rst_busy", {31'd0, out_busy}, 32'd0);
    check("mid_rst_rd", {31'd0, read_done}, 32'd0);
    check("mid_rst_data", {16'd0, data_out}, 32'd0);
    check("mid_rst_drop", {31'd0, drop_err}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("in_rst_rd", {31'd0, read_done}, 32'd0);
    end
    rst_n = 1'b1;
    send(1'b0, 30'd7, '0);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      check("post_rst_rd_early", {31'd0, read_done}, 32'd0);
    end
    @(negedge clk);
    check("post_rst_rd", {31'd0, read_done}, 32'd1);
    check("post_rst_data", {16'd0, data_out}, 32'h0007);
    drain("drain_post_rst");

    check("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
